// File: rtl/occupancy_pkg.sv
// rtl/occupancy_pkg.sv - shared types and segment constants for the occupancy display
package occupancy_pkg;

   localparam int COUNT_W = 5;

   typedef logic [6:0] seg_t;

   // Active-low {g,f,e,d,c,b,a} glyphs used by the banner modes
   localparam seg_t SEG_C     = 7'b1000110;
   localparam seg_t SEG_L     = 7'b1000111;
   localparam seg_t SEG_E     = 7'b0000110;
   localparam seg_t SEG_A     = 7'b0001000;
   localparam seg_t SEG_R     = 7'b0101111;
   localparam seg_t SEG_F     = 7'b0001110;
   localparam seg_t SEG_U     = 7'b1000001;
   localparam seg_t SEG_ZERO  = 7'b1000000;
   localparam seg_t SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {CLEAR, COUNT, FULL} mode_t;

   typedef enum logic [1:0] {IDLE, CONV, LOAD} conv_state_t;

   // Shift-add-3 correction applied to one BCD nibble before each shift
   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/seg7_digit.sv
// rtl/seg7_digit.sv - BCD digit to active-low seven-segment code with blanking
module seg7_digit
   import occupancy_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output seg_t       seg
);

   // Decode one decimal digit; non-decimal codes and blank requests show nothing
   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/occupancy_display.sv
// rtl/occupancy_display.sv - occupancy count to six-digit HEX display with CLEAr0/count/FULL modes
module occupancy_display
   import occupancy_pkg::*;
#(
   parameter int CAPACITY   = 16,
   parameter int BLINK_HALF = 25_000_000
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [COUNT_W-1:0] count,
   output logic [6:0]         HEX0,
   output logic [6:0]         HEX1,
   output logic [6:0]         HEX2,
   output logic [6:0]         HEX3,
   output logic [6:0]         HEX4,
   output logic [6:0]         HEX5
);

   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   // {tens, ones, remaining binary bits}; binary bits shift into the BCD nibbles
   localparam int SR_W = 8 + COUNT_W;

   conv_state_t        state_q, state_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [2:0]         shift_cnt_q, shift_cnt_d;
   logic [COUNT_W-1:0] conv_val_q, conv_val_d;
   logic [COUNT_W-1:0] disp_val_q, disp_val_d;
   logic [3:0]         tens_q, tens_d;
   logic [3:0]         ones_q, ones_d;
   mode_t              mode_q, mode_d;
   logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
   logic               phase_q, phase_d;
   seg_t               hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
   seg_t               hex3_q, hex3_d, hex4_q, hex4_d, hex5_q, hex5_d;
   seg_t               tens_seg, ones_seg;

   function automatic mode_t mode_of(input logic [COUNT_W-1:0] v);
      if (v == '0)
         return CLEAR;
      else if (int'(v) >= CAPACITY)
         return FULL;
      else
         return COUNT;
   endfunction

   // Digit decoders look at the next-state digits so HEX registers load together with them
   seg7_digit u_tens (
      .bcd   (tens_d),
      .blank (tens_d == 4'd0),
      .seg   (tens_seg)
   );

   seg7_digit u_ones (
      .bcd   (ones_d),
      .blank (1'b0),
      .seg   (ones_seg)
   );

   // Converter FSM: sample a changed count, run five shift-add-3 steps, then publish
   always_comb begin
      count_d     = count;
      state_d     = state_q;
      sr_d        = sr_q;
      shift_cnt_d = shift_cnt_q;
      conv_val_d  = conv_val_q;
      disp_val_d  = disp_val_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      mode_d      = mode_q;
      case (state_q)
         IDLE: begin
            if (count_q != disp_val_q) begin
               sr_d        = {8'd0, count_q};
               conv_val_d  = count_q;
               shift_cnt_d = 3'd0;
               state_d     = CONV;
            end
         end
         CONV: begin
            sr_d        = {add3(sr_q[SR_W-1 -: 4]), add3(sr_q[SR_W-5 -: 4]), sr_q[COUNT_W-1:0]} << 1;
            shift_cnt_d = shift_cnt_q + 3'd1;
            if (shift_cnt_q == 3'(COUNT_W - 1))
               state_d = LOAD;
         end
         LOAD: begin
            tens_d     = sr_q[SR_W-1 -: 4];
            ones_d     = sr_q[SR_W-5 -: 4];
            disp_val_d = conv_val_q;
            mode_d     = mode_of(conv_val_q);
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Blink timer: restarts with letters visible on FULL entry, idles outside FULL
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (mode_d != FULL || mode_q != FULL) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end
   end

   // Output mux: choose banner/count glyphs from the next-state mode and digits
   always_comb begin
      hex5_d = SEG_BLANK;
      hex4_d = SEG_BLANK;
      hex3_d = SEG_BLANK;
      hex2_d = SEG_BLANK;
      hex1_d = tens_seg;
      hex0_d = ones_seg;
      case (mode_d)
         CLEAR: begin
            hex5_d = SEG_C;
            hex4_d = SEG_L;
            hex3_d = SEG_E;
            hex2_d = SEG_A;
            hex1_d = SEG_R;
            hex0_d = SEG_ZERO;
         end
         FULL: begin
            if (phase_d) begin
               hex5_d = SEG_F;
               hex4_d = SEG_U;
               hex3_d = SEG_L;
               hex2_d = SEG_L;
            end
         end
         default: ;
      endcase
   end

   // State register; reset abandons any conversion and shows CLEAr0
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         state_q     <= IDLE;
         sr_q        <= '0;
         shift_cnt_q <= 3'd0;
         conv_val_q  <= '0;
         disp_val_q  <= '0;
         tens_q      <= 4'd0;
         ones_q      <= 4'd0;
         mode_q      <= CLEAR;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
         hex5_q      <= SEG_C;
         hex4_q      <= SEG_L;
         hex3_q      <= SEG_E;
         hex2_q      <= SEG_A;
         hex1_q      <= SEG_R;
         hex0_q      <= SEG_ZERO;
      end else begin
         count_q     <= count_d;
         state_q     <= state_d;
         sr_q        <= sr_d;
         shift_cnt_q <= shift_cnt_d;
         conv_val_q  <= conv_val_d;
         disp_val_q  <= disp_val_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         mode_q      <= mode_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         hex5_q      <= hex5_d;
         hex4_q      <= hex4_d;
         hex3_q      <= hex3_d;
         hex2_q      <= hex2_d;
         hex1_q      <= hex1_d;
         hex0_q      <= hex0_d;
      end
   end

   assign HEX0 = hex0_q;
   assign HEX1 = hex1_q;
   assign HEX2 = hex2_q;
   assign HEX3 = hex3_q;
   assign HEX4 = hex4_q;
   assign HEX5 = hex5_q;

endmodule

// File: tb/tb_occupancy_display.sv
// tb/tb_occupancy_display.sv - scoreboard bench for occupancy_display
module tb_occupancy_display;

   localparam int BH  = 4;
   localparam int CAP = 16;

   localparam logic [6:0] S_C  = 7'b1000110;
   localparam logic [6:0] S_L  = 7'b1000111;
   localparam logic [6:0] S_E  = 7'b0000110;
   localparam logic [6:0] S_A  = 7'b0001000;
   localparam logic [6:0] S_R  = 7'b0101111;
   localparam logic [6:0] S_F  = 7'b0001110;
   localparam logic [6:0] S_U  = 7'b1000001;
   localparam logic [6:0] S_BL = 7'b1111111;
   localparam logic [27:0] FULL_L  = {S_F, S_U, S_L, S_L};
   localparam logic [27:0] BLANK_L = {S_BL, S_BL, S_BL, S_BL};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] count = 5'd0;
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

   always #5 clk = ~clk;

   occupancy_display #(.CAPACITY(CAP), .BLINK_HALF(BH)) dut (
      .clk   (clk),
      .reset (reset),
      .count (count),
      .HEX0  (hex0),
      .HEX1  (hex1),
      .HEX2  (hex2),
      .HEX3  (hex3),
      .HEX4  (hex4),
      .HEX5  (hex5)
   );

   typedef struct packed {
      int val;
      int cyc;
   } exp_t;

   exp_t q[$];
   int tests = 0;
   int fails = 0;
   int cyc = 0;

   function automatic logic [6:0] dig(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return S_BL;
      endcase
   endfunction

   // Whole display {HEX5..HEX0} for a value, letters shown in their visible phase
   function automatic logic [41:0] frame(input int v);
      logic [6:0] h1;
      if (v == 0)
         return {S_C, S_L, S_E, S_A, S_R, dig(0)};
      h1 = (v / 10 == 0) ? S_BL : dig(v / 10);
      return {((v >= CAP) ? FULL_L : BLANK_L), h1, dig(v % 10)};
   endfunction

   task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: a changed input is picked up when the converter is free and
   // shows up six edges after the pickup; reset shows CLEAr0 immediately.
   int m_cq = 0, m_disp = 0, m_busy = 0, m_conv = 0;
   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         if (m_disp != 0) q.push_back('{val: 0, cyc: cyc});
         m_cq = 0;
         m_disp = 0;
         m_busy = 0;
      end else begin
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_disp = m_conv;
               q.push_back('{val: m_disp, cyc: cyc});
            end
         end else if (m_cq != m_disp) begin
            m_conv = m_cq;
            m_busy = 6;
         end
         m_cq = int'(count);
      end
   end

   // Monitor: a change of the digit pair is a display update; pop and compare it
   logic [13:0] prev_sig = {7'b0101111, 7'b1000000};
   int cur_val = 0;
   always @(negedge clk) begin
      logic [13:0] sig;
      logic [41:0] act, expf;
      logic [27:0] lt;
      exp_t e;
      int prev_val;
      if (cyc > 0) begin
         sig = {hex1, hex0};
         act = {hex5, hex4, hex3, hex2, hex1, hex0};
         if (sig !== prev_sig) begin
            prev_sig = sig;
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_update: got %h at edge %0d, expected no change", sig, cyc);
            end else begin
               e = q.pop_front();
               tests++;
               if (cyc != e.cyc) begin
                  fails++;
                  $display("FAIL latency_val%0d: appeared at edge %0d, expected edge %0d", e.val, cyc, e.cyc);
               end
               prev_val = cur_val;
               cur_val = e.val;
               expf = frame(e.val);
               if (prev_val >= CAP && e.val >= CAP)
                  chk("update_digits", {28'd0, act[13:0]}, {28'd0, expf[13:0]});
               else
                  chk("update_frame", act, expf);
            end
         end else if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL overdue_val%0d: not shown by edge %0d, expected at edge %0d", e.val, cyc, e.cyc);
         end
         lt = act[41:14];
         if (cur_val >= CAP) begin
            tests++;
            if (lt !== FULL_L && lt !== BLANK_L) begin
               fails++;
               $display("FAIL full_letters: got %h, expected FULL or blank", lt);
            end
         end else begin
            expf = frame(cur_val);
            chk("steady_letters", {14'd0, lt}, {14'd0, expf[41:14]});
         end
      end
   end

   task automatic set_hold(input int v, input int n);
      count = 5'(v);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [41:0] f;
      reset = 1'b1;
      count = 5'd0;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_frame", {hex5, hex4, hex3, hex2, hex1, hex0}, frame(0));
      repeat (3) begin
         @(negedge clk);
         chk("reset_hold", {hex5, hex4, hex3, hex2, hex1, hex0}, frame(0));
      end

      set_hold(5, 12);
      set_hold(12, 12);
      set_hold(15, 12);

      // FULL entry: letters visible for BH cycles, then blank for BH, digits steady
      count = 5'd16;
      repeat (8) @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         f = {(((k / BH) % 2 == 0) ? FULL_L : BLANK_L), dig(1), dig(6)};
         chk($sformatf("blink_k%0d", k), {hex5, hex4, hex3, hex2, hex1, hex0}, f);
         @(negedge clk);
      end
      set_hold(15, 12);
      set_hold(31, 12);
      set_hold(10, 12);

      // Change during conversion: 5 completes, then 9
      set_hold(5, 4);
      set_hold(9, 20);

      // Reset in the middle of converting 23
      set_hold(23, 4);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_midconv", {hex5, hex4, hex3, hex2, hex1, hex0}, frame(0));
      reset = 1'b0;
      repeat (12) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 14) == 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
         set_hold(int'($urandom_range(0, 31)), int'($urandom_range(1, 18)));
      end

      repeat (30) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d updates still pending, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
